// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered single-cycle integer ALU
//
// Purpose:
//   Arithmetic (MODE=1) and logical (MODE=0) command sets on two WIDTH-bit
//   unsigned operands. Every output is registered: with CE=1 the outputs
//   show the result of the inputs sampled at that rising edge; with CE=0
//   everything holds. rst is synchronous, active-high and beats CE.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset (clears all outputs)
//   OPA, OPB   operands (WIDTH bits)
//   CMD        operation code (CMD_WIDTH+1 bits)
//   CIN        carry/borrow-in for ADD_CIN / SUB_CIN
//   CE         clock enable; 0 holds all outputs
//   MODE       1 = arithmetic set, 0 = logical set
//   INP_VALID  bit0 = OPA valid, bit1 = OPB valid
//   RES        result (WIDTH+1 bits)
//   OFLOW      borrow / underflow
//   COUT       carry-out
//   E, G, L    compare equal / greater / less
//   ERR        illegal command or missing operand
//
// Build option:
//   ALU_ROTATE_EN  when defined, logical CMD 12/13 are ROL_A_B / ROR_A_B
//                  (A rotated by the low log2(WIDTH) bits of B). Otherwise
//                  those codes are illegal.
// ---------------------------------------------------------------------------
module alu #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     OPA,
  input  logic [WIDTH-1:0]     OPB,
  input  logic [CMD_WIDTH:0]   CMD,
  input  logic                 CIN,
  input  logic                 CE,
  input  logic                 MODE,
  input  logic [1:0]           INP_VALID,
  output logic [WIDTH:0]       RES,
  output logic                 OFLOW,
  output logic                 COUT,
  output logic                 E,
  output logic                 G,
  output logic                 L,
  output logic                 ERR
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  // Zero-extended operands so carries and borrows land in bit WIDTH.
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] cin_ext;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] sum_cin;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] diff_cin;
  logic [WIDTH:0] b_plus_cin;

  assign a_ext      = {1'b0, OPA};
  assign b_ext      = {1'b0, OPB};
  assign cin_ext    = {{WIDTH{1'b0}}, CIN};
  assign sum        = a_ext + b_ext;
  assign sum_cin    = sum + cin_ext;
  assign diff       = a_ext - b_ext;
  assign diff_cin   = diff - cin_ext;
  // Cannot overflow WIDTH+1 bits, so the borrow test below is exact.
  assign b_plus_cin = b_ext + cin_ext;

`ifdef ALU_ROTATE_EN
  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   rot_amt;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic             rot_range_err;

  assign rot_amt       = OPB[SHW-1:0];
  // Any set bit above the rotate field is flagged, the rotate still happens.
  assign rot_range_err = |OPB[WIDTH-1:SHW];

  // Each output bit selects its source bit; the SHW-bit index arithmetic
  // wraps modulo WIDTH, which is exactly the rotate.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign rol_val[gi] = OPA[SHW'(gi) - rot_amt];
      assign ror_val[gi] = OPA[SHW'(gi) + rot_amt];
    end
  endgenerate
`endif

  logic [WIDTH:0] res_next;
  logic           oflow_next;
  logic           cout_next;
  logic           e_next;
  logic           g_next;
  logic           l_next;
  logic           err_next;
  logic           need_a;
  logic           need_b;
  logic           legal;

  always_comb begin
    res_next   = '0;
    oflow_next = 1'b0;
    cout_next  = 1'b0;
    e_next     = 1'b0;
    g_next     = 1'b0;
    l_next     = 1'b0;
    err_next   = 1'b0;
    need_a     = 1'b0;
    need_b     = 1'b0;
    legal      = 1'b1;

    if (MODE) begin
      case (int'(CMD))
        0: begin
          need_a = 1'b1; need_b = 1'b1;
          res_next  = sum;
          cout_next = sum[WIDTH];
        end
        1: begin
          need_a = 1'b1; need_b = 1'b1;
          res_next   = diff;
          oflow_next = (a_ext < b_ext);
        end
        2: begin
          need_a = 1'b1; need_b = 1'b1;
          res_next  = sum_cin;
          cout_next = sum_cin[WIDTH];
        end
        3: begin
          need_a = 1'b1; need_b = 1'b1;
          res_next   = diff_cin;
          oflow_next = (a_ext < b_plus_cin);
        end
        4: begin
          need_a   = 1'b1;
          res_next = a_ext + ONE;
        end
        5: begin
          need_a     = 1'b1;
          res_next   = a_ext - ONE;
          oflow_next = (OPA == '0);
        end
        6: begin
          need_b   = 1'b1;
          res_next = b_ext + ONE;
        end
        7: begin
          need_b     = 1'b1;
          res_next   = b_ext - ONE;
          oflow_next = (OPB == '0);
        end
        8: begin
          need_a = 1'b1; need_b = 1'b1;
          e_next = (OPA == OPB);
          g_next = (OPA > OPB);
          l_next = (OPA < OPB);
        end
        default: legal = 1'b0;
      endcase
    end else begin
      case (int'(CMD))
        0:  begin need_a = 1'b1; need_b = 1'b1; res_next = {1'b0, OPA & OPB};    end
        1:  begin need_a = 1'b1; need_b = 1'b1; res_next = {1'b0, ~(OPA & OPB)}; end
        2:  begin need_a = 1'b1; need_b = 1'b1; res_next = {1'b0, OPA | OPB};    end
        3:  begin need_a = 1'b1; need_b = 1'b1; res_next = {1'b0, ~(OPA | OPB)}; end
        4:  begin need_a = 1'b1; need_b = 1'b1; res_next = {1'b0, OPA ^ OPB};    end
        5:  begin need_a = 1'b1; need_b = 1'b1; res_next = {1'b0, ~(OPA ^ OPB)}; end
        6:  begin need_a = 1'b1; res_next = {1'b0, ~OPA}; end
        7:  begin need_b = 1'b1; res_next = {1'b0, ~OPB}; end
        8:  begin need_a = 1'b1; res_next = {2'b00, OPA[WIDTH-1:1]}; end
        9:  begin need_a = 1'b1; res_next = {1'b0, OPA[WIDTH-2:0], 1'b0}; end
        10: begin need_b = 1'b1; res_next = {2'b00, OPB[WIDTH-1:1]}; end
        11: begin need_b = 1'b1; res_next = {1'b0, OPB[WIDTH-2:0], 1'b0}; end
`ifdef ALU_ROTATE_EN
        12: begin
          need_a = 1'b1; need_b = 1'b1;
          res_next = {1'b0, rol_val};
          err_next = rot_range_err;
        end
        13: begin
          need_a = 1'b1; need_b = 1'b1;
          res_next = {1'b0, ror_val};
          err_next = rot_range_err;
        end
`endif
        default: legal = 1'b0;
      endcase
    end

    // Illegal code or a missing required operand: only ERR survives.
    if (!legal || (need_a && !INP_VALID[0]) || (need_b && !INP_VALID[1])) begin
      res_next   = '0;
      oflow_next = 1'b0;
      cout_next  = 1'b0;
      e_next     = 1'b0;
      g_next     = 1'b0;
      l_next     = 1'b0;
      err_next   = 1'b1;
    end
  end

  logic [WIDTH:0] res_reg;
  logic           oflow_reg;
  logic           cout_reg;
  logic           e_reg;
  logic           g_reg;
  logic           l_reg;
  logic           err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_reg   <= '0;
      oflow_reg <= 1'b0;
      cout_reg  <= 1'b0;
      e_reg     <= 1'b0;
      g_reg     <= 1'b0;
      l_reg     <= 1'b0;
      err_reg   <= 1'b0;
    end else if (CE) begin
      res_reg   <= res_next;
      oflow_reg <= oflow_next;
      cout_reg  <= cout_next;
      e_reg     <= e_next;
      g_reg     <= g_next;
      l_reg     <= l_next;
      err_reg   <= err_next;
    end
  end

  assign RES   = res_reg;
  assign OFLOW = oflow_reg;
  assign COUT  = cout_reg;
  assign E     = e_reg;
  assign G     = g_reg;
  assign L     = l_reg;
  assign ERR   = err_reg;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (WIDTH=8)
//
// Directed steps from the plan followed by randomized traffic. Each step
// drives inputs on the falling edge, lets one rising edge pass and compares
// the packed output vector {RES,OFLOW,COUT,E,G,L,ERR} against an integer
// reference model. Honours ALU_ROTATE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_alu;

  localparam int W  = 8;
  localparam int M  = 1 << W;
  localparam int M2 = 1 << (W + 1);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] OPA;
  logic [W-1:0] OPB;
  logic [3:0]   CMD;
  logic         CIN;
  logic         CE;
  logic         MODE;
  logic [1:0]   INP_VALID;
  logic [W:0]   RES;
  logic         OFLOW;
  logic         COUT;
  logic         E;
  logic         G;
  logic         L;
  logic         ERR;

  int tests = 0;
  int fails = 0;
  logic [14:0] exp_v = '0;

  alu #(.WIDTH(W), .CMD_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .OPA(OPA), .OPB(OPB), .CMD(CMD), .CIN(CIN),
    .CE(CE), .MODE(MODE), .INP_VALID(INP_VALID), .RES(RES), .OFLOW(OFLOW),
    .COUT(COUT), .E(E), .G(G), .L(L), .ERR(ERR)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] mk(int res, bit o, bit c, bit e, bit g, bit l, bit err);
    return {9'(res), o, c, e, g, l, err};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {RES, OFLOW, COUT, E, G, L, ERR};
  endfunction

  // Reference: plain integer arithmetic on the operation rules.
  function automatic logic [14:0] model(bit mode, int cmd, int a, int b, bit cin, bit [1:0] iv);
    int r = 0;
    bit o = 0, c = 0, e = 0, g = 0, l = 0, err = 0;
    bit na = 0, nb = 0, legal = 1;
    int amt;
    if (mode) begin
      case (cmd)
        0: begin na = 1; nb = 1; r = a + b; c = (r >= M); end
        1: begin na = 1; nb = 1; r = (a - b + M2) % M2; o = (a < b); end
        2: begin na = 1; nb = 1; r = a + b + cin; c = (r >= M); end
        3: begin na = 1; nb = 1; r = (a - b - cin + M2) % M2; o = (a < b + cin); end
        4: begin na = 1; r = a + 1; end
        5: begin na = 1; r = (a - 1 + M2) % M2; o = (a == 0); end
        6: begin nb = 1; r = b + 1; end
        7: begin nb = 1; r = (b - 1 + M2) % M2; o = (b == 0); end
        8: begin na = 1; nb = 1; e = (a == b); g = (a > b); l = (a < b); end
        default: legal = 0;
      endcase
    end else begin
      case (cmd)
        0: begin na = 1; nb = 1; r = a & b; end
        1: begin na = 1; nb = 1; r = (M - 1) - (a & b); end
        2: begin na = 1; nb = 1; r = a | b; end
        3: begin na = 1; nb = 1; r = (M - 1) - (a | b); end
        4: begin na = 1; nb = 1; r = a ^ b; end
        5: begin na = 1; nb = 1; r = (M - 1) - (a ^ b); end
        6: begin na = 1; r = (M - 1) - a; end
        7: begin nb = 1; r = (M - 1) - b; end
        8: begin na = 1; r = a / 2; end
        9: begin na = 1; r = (a * 2) % M; end
        10: begin nb = 1; r = b / 2; end
        11: begin nb = 1; r = (b * 2) % M; end
`ifdef ALU_ROTATE_EN
        12, 13: begin
          na = 1; nb = 1;
          amt = b % W;
          if (cmd == 12) r = ((a * (1 << amt)) + a / (1 << (W - amt))) % M;
          else           r = (a / (1 << amt) + a * (1 << (W - amt))) % M;
          err = (b >= W);
        end
`endif
        default: legal = 0;
      endcase
    end
    if (!legal || (na && !iv[0]) || (nb && !iv[1])) begin
      r = 0; o = 0; c = 0; e = 0; g = 0; l = 0; err = 1;
    end
    return mk(r, o, c, e, g, l, err);
  endfunction

  task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input string tag, input bit r, input bit ce, input bit mode,
                      input int cmd, input int a, input int b, input bit cin,
                      input bit [1:0] iv);
    @(negedge clk);
    rst = r; CE = ce; MODE = mode; CMD = 4'(cmd);
    OPA = 8'(a); OPB = 8'(b); CIN = cin; INP_VALID = iv;
    if (r)       exp_v = '0;
    else if (ce) exp_v = model(mode, cmd, a, b, cin, iv);
    @(posedge clk);
    #1;
    check(tag, dut_vec(), exp_v);
  endtask

  initial begin
    rst = 1'b1; CE = 1'b0; MODE = 1'b0; CMD = '0; OPA = '0; OPB = '0;
    CIN = 1'b0; INP_VALID = 2'b00;

    step("reset_init", 1, 0, 0, 0, 0, 0, 0, 2'b00);

    step("add_ff_01", 0, 1, 1, 0, 8'hFF, 8'h01, 0, 2'b11);
    check("add_lit", dut_vec(), mk(9'h100, 0, 1, 0, 0, 0, 0));

    step("sub_5_7", 0, 1, 1, 1, 8'h05, 8'h07, 0, 2'b11);
    check("sub_lit", dut_vec(), mk(9'h1FE, 1, 0, 0, 0, 0, 0));

    step("cmp_eq", 0, 1, 1, 8, 8'h3C, 8'h3C, 0, 2'b11);
    check("cmp_eq_lit", dut_vec(), mk(0, 0, 0, 1, 0, 0, 0));

    step("cmp_lt", 0, 1, 1, 8, 8'h10, 8'h20, 0, 2'b11);
    check("cmp_lt_lit", dut_vec(), mk(0, 0, 0, 0, 0, 1, 0));

    step("and_missing_b", 0, 1, 0, 0, 8'hAA, 8'h55, 0, 2'b01);
    check("and_missing_lit", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1));

    step("inc_a_ff", 0, 1, 1, 4, 8'hFF, 8'h00, 0, 2'b01);
    check("inc_a_lit", dut_vec(), mk(9'h100, 0, 0, 0, 0, 0, 0));

    step("arith_illegal_12", 0, 1, 1, 12, 8'h12, 8'h34, 0, 2'b11);
    check("illegal_lit", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1));

    step("dec_a_zero", 0, 1, 1, 5, 8'h00, 8'h00, 0, 2'b01);
    check("dec_a_lit", dut_vec(), mk(9'h1FF, 1, 0, 0, 0, 0, 0));

    step("sub_cin_eq", 0, 1, 1, 3, 8'h07, 8'h07, 1, 2'b11);
    check("sub_cin_lit", dut_vec(), mk(9'h1FF, 1, 0, 0, 0, 0, 0));

    step("shl_a", 0, 1, 0, 9, 8'h81, 8'h00, 0, 2'b01);
    check("shl_a_lit", dut_vec(), mk(9'h002, 0, 0, 0, 0, 0, 0));

    step("iv_00", 0, 1, 1, 0, 8'h01, 8'h01, 0, 2'b00);
    check("iv_00_lit", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1));

    step("rol_81_1", 0, 1, 0, 12, 8'h81, 8'h01, 0, 2'b11);
`ifdef ALU_ROTATE_EN
    check("rol_lit", dut_vec(), mk(9'h003, 0, 0, 0, 0, 0, 0));
    step("rol_81_11", 0, 1, 0, 12, 8'h81, 8'h11, 0, 2'b11);
    check("rol_range_lit", dut_vec(), mk(9'h003, 0, 0, 0, 0, 0, 1));
    step("ror_81_1", 0, 1, 0, 13, 8'h81, 8'h01, 0, 2'b11);
    check("ror_lit", dut_vec(), mk(9'h0C0, 0, 0, 0, 0, 0, 0));
`else
    check("rol_disabled_lit", dut_vec(), mk(0, 0, 0, 0, 0, 0, 1));
`endif

    // Hold: a known result, then three CE=0 cycles with changing inputs
    // (including an illegal code, which must not raise ERR).
    step("hold_setup", 0, 1, 1, 0, 8'hFF, 8'h01, 0, 2'b11);
    step("hold_1", 0, 0, 1, 15, 8'h00, 8'h00, 0, 2'b00);
    step("hold_2", 0, 0, 0, 14, 8'h12, 8'h34, 1, 2'b11);
    step("hold_3", 0, 0, 1, 1, 8'h01, 8'h02, 0, 2'b11);
    check("hold_lit", dut_vec(), mk(9'h100, 0, 1, 0, 0, 0, 0));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit [1:0] iv;
      iv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      step($sformatf("rand_%0d", i), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 5) != 0), 1'($urandom), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           1'($urandom), iv);
    end

    // Reset after arbitrary traffic: rst wins over CE for both cycles.
    step("pre_reset", 0, 1, 1, 0, 8'hF0, 8'hF0, 0, 2'b11);
    step("reset_1", 1, 1, 1, 0, 8'hF0, 8'hF0, 0, 2'b11);
    step("reset_2", 1, 0, 1, 0, 8'hF0, 8'hF0, 0, 2'b11);
    check("reset_lit", dut_vec(), mk(0, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
